// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the RV32 register file and its pending-write scoreboard.
package reg_file_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic [1:0] {SRC_ZERO, SRC_ARRAY, SRC_WB0, SRC_WB1} rd_src_e;

   function automatic int addr_width(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

   function automatic int pmax_of(input int pcw);
      return (1 << pcw) - 1;
   endfunction

   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue reservations, write-back releases,
// RAW busy indication and a sticky underflow flag.
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int  NREGS  = NREGS_DEF,
   parameter int  NUM_RD = 2,
   parameter int  BYPASS = 1,
   parameter int  PCW    = 2,
   localparam int AW     = addr_width(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   output logic                 iss_ready,
   input  logic                 wb0_en,
   input  logic [AW-1:0]        wb0_addr,
   input  logic                 wb1_en,
   input  logic [AW-1:0]        wb1_addr,
   input  logic                 flush,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD-1:0]    rd_busy,
   output logic                 busy_any,
   output logic                 err_underflow
);
   localparam int PMAX = pmax_of(PCW);

   typedef logic [AW-1:0] addr_t;
   typedef logic [PCW-1:0] cnt_t;
   typedef logic [PCW:0]   wide_t;

   localparam cnt_t PMAX_C = cnt_t'(PMAX);

   cnt_t             cnt     [NREGS];
   cnt_t             cnt_nxt [NREGS];
   logic [1:0]       dec     [NREGS];
   logic [NREGS-1:0] clip;
   wide_t            sum_w;
   wide_t            dec_w;
   logic             inc;
   addr_t            ra;

   assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != PMAX_C);

   // A reservation is only accepted when not at PMAX, so cnt+inc never exceeds PMAX;
   // the subtraction is clipped at zero and the clip is reported as underflow.
   always_comb begin
      sum_w = '0;
      dec_w = '0;
      inc   = 1'b0;
      clip  = '0;
      for (int r = 0; r < NREGS; r++) begin
         dec[r]     = {1'b0, wb0_en && (wb0_addr == addr_t'(r))}
                    + {1'b0, wb1_en && (wb1_addr == addr_t'(r))};
         inc        = iss_valid && iss_ready && (iss_rd == addr_t'(r)) && (r != 0);
         sum_w      = wide_t'(cnt[r]) + wide_t'(inc);
         dec_w      = wide_t'(dec[r]);
         cnt_nxt[r] = '0;
         if (r != 0) begin
            clip[r] = dec_w > sum_w;
            if (!clip[r]) cnt_nxt[r] = cnt_t'(sum_w - dec_w);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
         err_underflow <= 1'b0;
      end else if (flush) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
         if (|clip) err_underflow <= 1'b1;
      end
   end

   always_comb begin
      busy_any = 1'b0;
      for (int r = 0; r < NREGS; r++) busy_any = busy_any | (cnt[r] != '0);
   end

   // With bypass, a producer writing back this cycle no longer counts as outstanding.
   always_comb begin
      rd_busy = '0;
      ra      = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = rd_addr[slice_lo(k, AW) +: AW];
         if (BYPASS != 0) rd_busy[k] = wide_t'(cnt[ra]) > wide_t'(dec[ra]);
         else             rd_busy[k] = cnt[ra] != '0;
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// RV32 general-purpose register file: two prioritised write-back ports, N combinational
// read ports with optional write-to-read bypass, and an integrated pending-write scoreboard.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int  XLEN   = XLEN_DEF,
   parameter int  NREGS  = NREGS_DEF,
   parameter int  NUM_RD = 2,
   parameter int  BYPASS = 1,
   parameter int  PCW    = 2,
   localparam int AW     = addr_width(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_rd,
   output logic                   iss_ready,
   input  logic                   wb0_en,
   input  logic [AW-1:0]          wb0_addr,
   input  logic [XLEN-1:0]        wb0_data,
   input  logic                   wb1_en,
   input  logic [AW-1:0]          wb1_addr,
   input  logic [XLEN-1:0]        wb1_data,
   input  logic                   flush,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   output logic                   busy_any,
   output logic                   err_underflow
);
   typedef logic [AW-1:0] addr_t;

   logic [XLEN-1:0] regs [NREGS];
   addr_t           ra;
   rd_src_e         src;

   // wb0 is written last so it wins when both ports target the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         if (wb1_en && (wb1_addr != '0)) regs[wb1_addr] <= wb1_data;
         if (wb0_en && (wb0_addr != '0)) regs[wb0_addr] <= wb0_data;
      end
   end

   always_comb begin
      rd_data = '0;
      ra      = '0;
      src     = SRC_ZERO;
      for (int k = 0; k < NUM_RD; k++) begin
         ra  = rd_addr[slice_lo(k, AW) +: AW];
         src = SRC_ARRAY;
         if ((BYPASS != 0) && wb1_en && (wb1_addr == ra)) src = SRC_WB1;
         if ((BYPASS != 0) && wb0_en && (wb0_addr == ra)) src = SRC_WB0;
         if (rst || (ra == '0)) src = SRC_ZERO;
         case (src)
            SRC_WB0:   rd_data[slice_lo(k, XLEN) +: XLEN] = wb0_data;
            SRC_WB1:   rd_data[slice_lo(k, XLEN) +: XLEN] = wb1_data;
            SRC_ARRAY: rd_data[slice_lo(k, XLEN) +: XLEN] = regs[ra];
            default:   rd_data[slice_lo(k, XLEN) +: XLEN] = '0;
         endcase
      end
   end

   rf_scoreboard #(
      .NREGS  (NREGS),
      .NUM_RD (NUM_RD),
      .BYPASS (BYPASS),
      .PCW    (PCW)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_ready     (iss_ready),
      .wb0_en        (wb0_en),
      .wb0_addr      (wb0_addr),
      .wb1_en        (wb1_en),
      .wb1_addr      (wb1_addr),
      .flush         (flush),
      .rd_addr       (rd_addr),
      .rd_busy       (rd_busy),
      .busy_any      (busy_any),
      .err_underflow (err_underflow)
   );
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (BYPASS=1, PCW=2): stimulus queues expected values,
// a negedge monitor pops and compares them in the cycle they were issued for.
module tb_reg_file_sb;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 2;
   localparam int AW     = 5;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   iss_valid = 1'b0;
   logic [AW-1:0]          iss_rd = '0;
   logic                   iss_ready;
   logic                   wb0_en = 1'b0;
   logic [AW-1:0]          wb0_addr = '0;
   logic [XLEN-1:0]        wb0_data = '0;
   logic                   wb1_en = 1'b0;
   logic [AW-1:0]          wb1_addr = '0;
   logic [XLEN-1:0]        wb1_data = '0;
   logic                   flush = 1'b0;
   logic [NUM_RD*AW-1:0]   rd_addr = '0;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic                   busy_any;
   logic                   err_underflow;

   reg_file_sb #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NUM_RD (NUM_RD),
      .BYPASS (1),
      .PCW    (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_ready     (iss_ready),
      .wb0_en        (wb0_en),
      .wb0_addr      (wb0_addr),
      .wb0_data      (wb0_data),
      .wb1_en        (wb1_en),
      .wb1_addr      (wb1_addr),
      .wb1_data      (wb1_data),
      .flush         (flush),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_busy       (rd_busy),
      .busy_any      (busy_any),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   typedef enum int {K_DATA, K_BUSY, K_READY, K_ANY, K_ERR} kind_e;
   typedef struct {
      int          cyc;
      string       name;
      kind_e       kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t expq[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
         e = expq.pop_front();
         case (e.kind)
            K_DATA:  act = rd_data[e.port*XLEN +: XLEN];
            K_BUSY:  act = {31'b0, rd_busy[e.port]};
            K_READY: act = {31'b0, iss_ready};
            K_ANY:   act = {31'b0, busy_any};
            default: act = {31'b0, err_underflow};
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d, sampled %0d): got 0x%08h, expected 0x%08h",
                     e.name, e.cyc, cyc, act, e.val);
         end
      end
   end

   task automatic applyStimulus(input logic rs, input logic iv, input logic [AW-1:0] ird,
                                input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
                                input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
                                input logic fl, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      @(posedge clk);
      #1;
      rst       = rs;
      iss_valid = iv;
      iss_rd    = ird;
      wb0_en    = w0e;
      wb0_addr  = w0a;
      wb0_data  = w0d;
      wb1_en    = w1e;
      wb1_addr  = w1a;
      wb1_data  = w1d;
      flush     = fl;
      rd_addr   = {ra1, ra0};
   endtask

   task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      applyStimulus(0, 0, '0, 0, '0, '0, 0, '0, '0, 0, ra0, ra1);
   endtask

   task automatic checkOutput(input string name, input kind_e kind, input int port,
                              input logic [31:0] val);
      expq.push_back('{cyc: cyc, name: name, kind: kind, port: port, val: val});
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Held in reset with live write-back and issue: outputs must stay cleared.
      applyStimulus(1, 1, 5, 1, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 5, 0);
      checkOutput("rst_rd0",   K_DATA,  0, 0);
      checkOutput("rst_busy0", K_BUSY,  0, 0);
      checkOutput("rst_ready", K_READY, 0, 1);
      checkOutput("rst_any",   K_ANY,   0, 0);
      checkOutput("rst_err",   K_ERR,   0, 0);

      for (int a = 0; a < NREGS; a++) begin
         idle(AW'(a), AW'(NREGS - 1 - a));
         checkOutput($sformatf("sweep_rd0_x%0d", a),   K_DATA, 0, 0);
         checkOutput($sformatf("sweep_rd1_x%0d", a),   K_DATA, 1, 0);
         checkOutput($sformatf("sweep_busy0_x%0d", a), K_BUSY, 0, 0);
         checkOutput($sformatf("sweep_busy1_x%0d", a), K_BUSY, 1, 0);
      end
      checkOutput("sweep_ready", K_READY, 0, 1);
      checkOutput("sweep_any",   K_ANY,   0, 0);

      // x0 is hardwired to zero, even through bypass.
      applyStimulus(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_bypass", K_DATA, 0, 0);
      idle(0, 0);
      checkOutput("x0_after", K_DATA, 0, 0);
      checkOutput("x0_noerr", K_ERR,  0, 0);

      // Issue x5, write back two cycles later with bypass.
      applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      checkOutput("x5_iss_ready", K_READY, 0, 1);
      checkOutput("x5_iss_busy",  K_BUSY,  0, 0);
      idle(5, 0);
      checkOutput("x5_pend_busy", K_BUSY, 0, 1);
      checkOutput("x5_pend_any",  K_ANY,  0, 1);
      checkOutput("x5_pend_data", K_DATA, 0, 0);
      applyStimulus(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, 5, 0);
      checkOutput("x5_byp_data", K_DATA, 0, 32'h1234);
      checkOutput("x5_byp_busy", K_BUSY, 0, 0);
      checkOutput("x5_byp_any",  K_ANY,  0, 1);
      idle(5, 5);
      checkOutput("x5_rd0", K_DATA, 0, 32'h1234);
      checkOutput("x5_rd1", K_DATA, 1, 32'h1234);
      checkOutput("x5_any", K_ANY,  0, 0);

      // Two producers to x7 retired by both ports at once; wb0 data wins.
      applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      applyStimulus(0, 0, 0, 1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 7, 7);
      checkOutput("x7_byp_rd0",  K_DATA, 0, 32'hAAAA);
      checkOutput("x7_byp_rd1",  K_DATA, 1, 32'hAAAA);
      checkOutput("x7_byp_busy", K_BUSY, 0, 0);
      idle(7, 0);
      checkOutput("x7_rd0",  K_DATA, 0, 32'hAAAA);
      checkOutput("x7_busy", K_BUSY, 0, 0);
      checkOutput("x7_err",  K_ERR,  0, 0);
      checkOutput("x7_any",  K_ANY,  0, 0);

      // Saturate x3 at PMAX=3 while iss_valid stays high.
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_ready_c0", K_READY, 0, 1);
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_ready_c1", K_READY, 0, 1);
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_ready_c2", K_READY, 0, 1);
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_full_ready", K_READY, 0, 0);
      checkOutput("x3_full_busy",  K_BUSY,  0, 1);
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_held_ready", K_READY, 0, 0);
      applyStimulus(0, 0, 3, 0, 0, 0, 1, 3, 32'h33, 0, 3, 0);
      checkOutput("x3_wb_ready", K_READY, 0, 0);
      checkOutput("x3_wb_busy",  K_BUSY,  0, 1);
      checkOutput("x3_wb1_byp",  K_DATA,  0, 32'h33);
      applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      checkOutput("x3_after_ready", K_READY, 0, 1);
      checkOutput("x3_after_busy",  K_BUSY,  0, 1);

      // Flush with simultaneous issue and write-back on x9.
      applyStimulus(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      applyStimulus(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      applyStimulus(0, 1, 9, 0, 0, 0, 1, 9, 32'h77, 1, 9, 0);
      checkOutput("x9_fl_ready", K_READY, 0, 1);
      checkOutput("x9_fl_busy",  K_BUSY,  0, 1);
      checkOutput("x9_fl_data",  K_DATA,  0, 32'h77);
      checkOutput("x9_fl_any",   K_ANY,   0, 1);
      idle(9, 3);
      checkOutput("x9_data",  K_DATA, 0, 32'h77);
      checkOutput("x9_busy",  K_BUSY, 0, 0);
      checkOutput("x3_busy",  K_BUSY, 1, 0);
      checkOutput("x3_data",  K_DATA, 1, 32'h33);
      checkOutput("fl_any",   K_ANY,  0, 0);
      checkOutput("fl_noerr", K_ERR,  0, 0);

      // Underflow on x12 is sticky.
      applyStimulus(0, 0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 12, 0);
      checkOutput("x12_busy",    K_BUSY, 0, 0);
      checkOutput("x12_err_pre", K_ERR,  0, 0);
      idle(12, 0);
      checkOutput("x12_err",  K_ERR,  0, 1);
      checkOutput("x12_data", K_DATA, 0, 32'hC);
      applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x12_err_hold", K_ERR, 0, 1);
      idle(4, 12);
      checkOutput("x4_any",       K_ANY,  0, 1);
      checkOutput("x4_busy",      K_BUSY, 0, 1);
      checkOutput("x12_err_hold2", K_ERR, 0, 1);
      checkOutput("x12_rd1",      K_DATA, 1, 32'hC);

      // Mid-run reset clears everything without waiting for an edge.
      applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4, 12);
      checkOutput("mrst_busy0", K_BUSY,  0, 0);
      checkOutput("mrst_rd1",   K_DATA,  1, 0);
      checkOutput("mrst_err",   K_ERR,   0, 0);
      checkOutput("mrst_any",   K_ANY,   0, 0);
      checkOutput("mrst_ready", K_READY, 0, 1);
      idle(7, 5);
      checkOutput("post_rd0_x7", K_DATA, 0, 0);
      checkOutput("post_rd1_x5", K_DATA, 1, 0);
      checkOutput("post_err",    K_ERR,  0, 0);

      // Post-reset: one producer on x4 retired by two ports clips and flags underflow.
      applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 4, 0);
      checkOutput("x4_iss_busy", K_BUSY, 0, 0);
      idle(4, 0);
      checkOutput("x4_pend_busy", K_BUSY, 0, 1);
      applyStimulus(0, 0, 0, 1, 4, 32'h44, 1, 4, 32'h55, 0, 4, 4);
      checkOutput("x4_dual_rd0",  K_DATA, 0, 32'h44);
      checkOutput("x4_dual_rd1",  K_DATA, 1, 32'h44);
      checkOutput("x4_dual_busy", K_BUSY, 0, 0);
      checkOutput("x4_dual_err",  K_ERR,  0, 0);
      idle(4, 0);
      checkOutput("x4_data", K_DATA, 0, 32'h44);
      checkOutput("x4_err",  K_ERR,  0, 1);
      checkOutput("x4_any",  K_ANY,  0, 0);

      for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
      if (expq.size() > 0) begin
         $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
         checks += expq.size();
         errors += expq.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
